// File: rtl/axi4_write_arbiter_if.sv
// Signal bundle between the write arbiter, its two requesters and the shared write master.
// The arbiter connects through the slave modport; requesters and write master use the master modport.
interface axi4_write_arbiter_if #(
   parameter int unsigned ADDR_W = 64,
   parameter int unsigned DATA_W = 64
);
   logic              R0_REQ;
   logic [ADDR_W-1:0] R0_ADDR;
   logic [DATA_W-1:0] R0_DATA;
   logic              R0_GNT;
   logic              R0_DONE;
   logic              R0_ERR;

   logic              R1_REQ;
   logic [ADDR_W-1:0] R1_ADDR;
   logic [DATA_W-1:0] R1_DATA;
   logic              R1_GNT;
   logic              R1_DONE;
   logic              R1_ERR;

   logic [ADDR_W-1:0] WRITE_ADDR;
   logic [DATA_W-1:0] WRITE_DATA;
   logic              WRITE_START;
   logic              WRITE_DONE;
   logic              BUSY;

   modport slave (
      input  R0_REQ, R0_ADDR, R0_DATA, R1_REQ, R1_ADDR, R1_DATA, WRITE_DONE,
      output R0_GNT, R0_DONE, R0_ERR, R1_GNT, R1_DONE, R1_ERR,
             WRITE_ADDR, WRITE_DATA, WRITE_START, BUSY
   );

   modport master (
      output R0_REQ, R0_ADDR, R0_DATA, R1_REQ, R1_ADDR, R1_DATA, WRITE_DONE,
      input  R0_GNT, R0_DONE, R0_ERR, R1_GNT, R1_DONE, R1_ERR,
             WRITE_ADDR, WRITE_DATA, WRITE_START, BUSY
   );
endinterface

// File: rtl/axi4_write_arbiter.sv
// Round-robin arbiter sharing one write master between two requesters, one transaction per grant,
// with a bounded wait so a hung slave completes with ERR instead of locking the master.
module axi4_write_arbiter #(
   parameter int unsigned ADDR_W  = 64,
   parameter int unsigned DATA_W  = 64,
   parameter int unsigned TIMEOUT = 1024
) (
   input logic                 CLK,
   input logic                 RST,
   axi4_write_arbiter_if.slave bus
);
   localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_WAIT,
      S_DONE
   } state_e;

   state_e              state_q, state_d;
   logic                owner_q, owner_d;
   logic                last_q,  last_d;
   logic                err_q,   err_d;
   logic [CNT_W-1:0]    cnt_q,   cnt_d;
   logic [ADDR_W-1:0]   addr_q,  addr_d;
   logic [DATA_W-1:0]   data_q,  data_d;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         err_q   <= 1'b0;
         cnt_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      data_d  = data_q;

      unique case (state_q)
         S_IDLE: begin
            // R0 takes a tie only when R1 was served last
            if (bus.R0_REQ && (!bus.R1_REQ || last_q)) begin
               owner_d = 1'b0;
               addr_d  = bus.R0_ADDR;
               data_d  = bus.R0_DATA;
               state_d = S_START;
            end else if (bus.R1_REQ) begin
               owner_d = 1'b1;
               addr_d  = bus.R1_ADDR;
               data_d  = bus.R1_DATA;
               state_d = S_START;
            end
         end
         S_START: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (bus.WRITE_DONE) begin
               err_d   = 1'b0;
               state_d = S_DONE;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            last_d  = owner_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.BUSY        = (state_q != S_IDLE);
   assign bus.WRITE_START = (state_q == S_START);
   assign bus.WRITE_ADDR  = addr_q;
   assign bus.WRITE_DATA  = data_q;

   assign bus.R0_GNT  = bus.BUSY && !owner_q;
   assign bus.R1_GNT  = bus.BUSY &&  owner_q;
   assign bus.R0_DONE = (state_q == S_DONE) && !owner_q;
   assign bus.R1_DONE = (state_q == S_DONE) &&  owner_q;
   assign bus.R0_ERR  = bus.R0_DONE && err_q;
   assign bus.R1_ERR  = bus.R1_DONE && err_q;
endmodule
